fetch_pc_ctrl: RTL and testbench
================================

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset_n  in  1  synchronous, active-low reset.
REQ-004 Port: stallF  in  1  hazard request to hold fetch (load-use); 1 = hold.
REQ-005 Port: pcSrcE  in  1  branch/jump taken, resolved in execute; 1 = redirect.
REQ-006 Port: pcTargetE  in  32  redirect target address from execute.
REQ-007 Port: pcF  out  32  registered fetch address to the fetch stage.
REQ-008 Port: fetchEnN  out  1  active-low enable for the fetch-to-decode register; 1 = hold contents.
REQ-009 Port: clrD  out  1  synchronous clear for the fetch-to-decode register; 1 = squash.
REQ-010 Port: stateOut  out  2  FSM state code: BOOT=0, RUN=1, HOLD=2.
REQ-011 Port: misalignErr  out  1  sticky flag: misaligned redirect target seen.
REQ-012 Port: stallCnt  out  16  saturating count of stall cycles honoured.
REQ-013 Port: flushCnt  out  16  saturating count of redirects taken.

Function
REQ-014 The block SHALL hold pcF in a 32-bit register; next-PC priority, highest first: reset, BOOT hold, redirect, stall hold, sequential.
REQ-015 Sequential next PC SHALL be pcF + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000, no flag).
REQ-016 Redirect: when pcSrcE=1 in RUN or HOLD, the next pcF SHALL be {pcTargetE[31:2], 2'b00}.
REQ-017 When pcSrcE=1 and pcTargetE[1:0]!=0, misalignErr SHALL set at the next edge and remain 1 until reset.
REQ-018 Redirect SHALL override stallF in the same cycle: PC loads target, fetchEnN=0, clrD=1.
REQ-019 clrD SHALL be combinational: 1 when state=BOOT, or pcSrcE=1 in RUN/HOLD; else 0.
REQ-020 fetchEnN SHALL be combinational: 1 when stallF=1 and pcSrcE=0 in RUN/HOLD; else 0.
REQ-021 Stall hold: stallF=1 and pcSrcE=0 in RUN/HOLD SHALL keep pcF unchanged at the next edge.
REQ-022 FSM transitions: BOOT -> RUN unconditionally after one cycle.
REQ-023 FSM transitions: RUN -> HOLD when stallF=1 and pcSrcE=0; else RUN.
REQ-024 FSM transitions: HOLD -> RUN when stallF=0 or pcSrcE=1; else HOLD.
REQ-025 In BOOT, pcF SHALL stay at RESET_PC; stallF and pcSrcE SHALL be ignored; counters SHALL not change.
REQ-026 stallCnt SHALL increment by 1 on each edge at which a stall hold (REQ-021) is honoured; saturate at 16'hFFFF.
REQ-027 flushCnt SHALL increment by 1 on each edge at which a redirect (REQ-016) is taken; saturate at 16'hFFFF.
REQ-028 Latency: pcSrcE/pcTargetE sampled at edge N SHALL appear on pcF after edge N; one wrong-path instruction is squashed via clrD.

Reset
REQ-029 On an edge with reset_n=0: pcF=RESET_PC, state=BOOT, stallCnt=0, flushCnt=0, misalignErr=0.
REQ-030 While reset_n=0, clrD SHALL be 1 and fetchEnN SHALL be 0, regardless of other inputs.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard the pending action; the first post-reset cycle is BOOT.

Verification
REQ-032 Boot: reset_n=0 for 2 cycles, then 1, no stall/redirect -> BOOT cycle with clrD=1 and pcF=0; then pcF=0,4,8,... each cycle with stateOut=1.
REQ-033 Stall: in RUN at pcF=0x10, stallF=1 for 3 cycles -> pcF held at 0x10, fetchEnN=1, stateOut=2, stallCnt=3; after release pcF=0x14 next edge.
REQ-034 Redirect: pcF=0x20, pcSrcE=1, pcTargetE=0x100 -> clrD=1 that cycle, pcF=0x100 next, flushCnt=1, then 0x104.
REQ-035 Simultaneous: stallF=1 with pcSrcE=1 and pcTargetE=0x200 -> fetchEnN=0, clrD=1, pcF=0x200 next, stallCnt unchanged, stateOut=1.
REQ-036 Misaligned and wrap: pcTargetE=0xFFFF_FFFE redirect -> pcF=0xFFFF_FFFC, misalignErr=1; next edge pcF=0x0000_0000; misalignErr stays 1 until reset.
REQ-037 Saturation: preload scenario of 65,540 stall cycles -> stallCnt holds 16'hFFFF, pcF unchanged throughout.

Source files
------------

// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_if
// Brief    : Hazard/execute-side signals and fetch-side results for the PC controller.
// Revision : 1.0
// ============================================================================
interface fetch_pc_ctrl_if;
    logic        stallF;
    logic        pcSrcE;
    logic [31:0] pcTargetE;
    logic [31:0] pcF;
    logic        fetchEnN;
    logic        clrD;
    logic [1:0]  stateOut;
    logic        misalignErr;
    logic [15:0] stallCnt;
    logic [15:0] flushCnt;

    modport master (
        output stallF, pcSrcE, pcTargetE,
        input  pcF, fetchEnN, clrD, stateOut, misalignErr, stallCnt, flushCnt
    );

    modport slave (
        input  stallF, pcSrcE, pcTargetE,
        output pcF, fetchEnN, clrD, stateOut, misalignErr, stallCnt, flushCnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Brief    : Fetch PC register with boot/run/hold FSM, redirect, stall and stats.
// Revision : 1.0
// ============================================================================
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    fetch_pc_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic        r_misalign;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_active;
    logic        w_redirect;
    logic        w_stall;

    // Redirect wins over stall; neither is honoured while booting.
    assign w_active   = (r_state == RUN) || (r_state == HOLD);
    assign w_redirect = w_active && bus.pcSrcE;
    assign w_stall    = w_active && bus.stallF && !bus.pcSrcE;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            BOOT:    w_state_nxt = RUN;
            RUN:     w_state_nxt = w_stall ? HOLD : RUN;
            HOLD:    w_state_nxt = w_stall ? HOLD : RUN;
            default: w_state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= {bus.pcTargetE[31:2], 2'b00};
        end else if (w_active && !w_stall) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_misalign  <= 1'b0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_redirect && (bus.pcTargetE[1:0] != 2'b00)) begin
                r_misalign <= 1'b1;
            end
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    // Decode-register controls are forced to squash/enable while in reset.
    assign bus.clrD        = !reset_n || (r_state == BOOT) || w_redirect;
    assign bus.fetchEnN    = reset_n && w_stall;
    assign bus.pcF         = r_pc;
    assign bus.stateOut    = r_state;
    assign bus.misalignErr = r_misalign;
    assign bus.stallCnt    = r_stall_cnt;
    assign bus.flushCnt    = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_ctrl
// Brief    : Directed plus random stimulus against a priority-rule reference model.
// Revision : 1.0
// ============================================================================
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_total;

    fetch_pc_ctrl_if bus ();

    fetch_pc_ctrl #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = boot, 1 = run, 2 = hold.
    logic [31:0] m_pc;
    int          m_phase;
    int          m_stalls;
    int          m_flushes;
    bit          m_mis;
    bit          m_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_edge(input bit st, input bit src, input logic [31:0] tgt, input bit rstn);
        if (!rstn) begin
            m_pc = RESET_PC; m_phase = 0; m_stalls = 0; m_flushes = 0; m_mis = 0; m_known = 1;
        end else if (!m_known) begin
            // state unknown until first reset; nothing to predict
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (src) begin
            m_pc = tgt & ~32'd3;
            if (tgt % 4 != 0) m_mis = 1;
            if (m_flushes < 65535) m_flushes++;
            m_phase = 1;
        end else if (st) begin
            if (m_stalls < 65535) m_stalls++;
            m_phase = 2;
        end else begin
            m_pc = m_pc + 32'd4;
            m_phase = 1;
        end
    endtask

    // One clock: apply inputs, check mid-cycle, advance model at the edge.
    task automatic cyc(input bit st, input bit src, input logic [31:0] tgt, input bit rstn);
        bit exp_clr;
        bit exp_hold;
        bus.stallF    = st;
        bus.pcSrcE    = src;
        bus.pcTargetE = tgt;
        reset_n       = rstn;
        @(negedge clk);
        exp_clr  = !rstn || (m_known && (m_phase == 0 || src));
        exp_hold = rstn && m_known && m_phase != 0 && st && !src;
        if (!rstn || m_known) begin
            chk("clrD", {31'd0, bus.clrD}, {31'd0, exp_clr});
            chk("fetchEnN", {31'd0, bus.fetchEnN}, {31'd0, exp_hold});
        end
        if (m_known) begin
            chk("pcF", bus.pcF, m_pc);
            chk("stateOut", {30'd0, bus.stateOut}, m_phase);
            chk("misalignErr", {31'd0, bus.misalignErr}, {31'd0, m_mis});
            chk("stallCnt", {16'd0, bus.stallCnt}, m_stalls);
            chk("flushCnt", {16'd0, bus.flushCnt}, m_flushes);
        end
        @(posedge clk);
        model_edge(st, src, tgt, rstn);
        #1;
    endtask

    initial begin
        n_pass = 0; n_total = 0; m_known = 0;
        m_pc = '0; m_phase = 0; m_stalls = 0; m_flushes = 0; m_mis = 0;
        reset_n = 1'b0; bus.stallF = 1'b0; bus.pcSrcE = 1'b0; bus.pcTargetE = '0;
        @(posedge clk); #1;

        // Boot: two reset cycles, boot cycle, then sequential fetch up to 0x10.
        cyc(1, 1, 32'h40, 0);
        cyc(0, 0, 32'h0, 0);
        cyc(1, 1, 32'h80, 1);
        repeat (4) cyc(0, 0, 32'h0, 1);
        chk("boot_pc_0x10", bus.pcF, 32'h10);

        // Stall three cycles, then release.
        repeat (3) cyc(1, 0, 32'h0, 1);
        chk("stall_cnt_3", {16'd0, bus.stallCnt}, 32'd3);
        chk("stall_pc_held", bus.pcF, 32'h10);
        cyc(0, 0, 32'h0, 1);
        chk("stall_release_pc", bus.pcF, 32'h14);

        // Redirect from 0x20 to 0x100.
        repeat (3) cyc(0, 0, 32'h0, 1);
        chk("pre_redirect_pc", bus.pcF, 32'h20);
        cyc(0, 1, 32'h100, 1);
        chk("redirect_pc", bus.pcF, 32'h100);
        chk("redirect_flush_1", {16'd0, bus.flushCnt}, 32'd1);
        cyc(0, 0, 32'h0, 1);

        // Redirect concurrent with stall; then from HOLD.
        cyc(1, 1, 32'h200, 1);
        chk("simul_pc", bus.pcF, 32'h200);
        chk("simul_stall_cnt", {16'd0, bus.stallCnt}, 32'd3);
        cyc(1, 0, 32'h0, 1);
        cyc(1, 1, 32'h300, 1);
        cyc(0, 0, 32'h0, 1);

        // Misaligned redirect to the top of memory, then wrap.
        cyc(0, 1, 32'hFFFF_FFFE, 1);
        chk("misalign_pc", bus.pcF, 32'hFFFF_FFFC);
        cyc(0, 0, 32'h0, 1);
        chk("wrap_pc", bus.pcF, 32'h0);
        repeat (3) cyc(0, 0, 32'h0, 1);
        chk("misalign_sticky", {31'd0, bus.misalignErr}, 32'd1);

        // Reset in the middle of a stall and of a redirect.
        cyc(1, 0, 32'h0, 1);
        cyc(1, 0, 32'h0, 0);
        cyc(1, 1, 32'h500, 1);
        cyc(0, 1, 32'h600, 0);
        cyc(0, 0, 32'h0, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          st;
            bit          src;
            bit          rstn;
            logic [31:0] tgt;
            st   = ($urandom_range(0, 2) == 0);
            src  = ($urandom_range(0, 5) == 0);
            rstn = ($urandom_range(0, 99) != 0);
            tgt  = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            cyc(st, src, tgt, rstn);
        end

        // Long stall run to reach counter saturation.
        cyc(0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 1);
        cyc(0, 0, 32'h0, 1);
        repeat (65540) cyc(1, 0, 32'h0, 1);
        chk("sat_stall_cnt", {16'd0, bus.stallCnt}, 32'h0000_FFFF);
        chk("sat_pc_held", bus.pcF, 32'h4);
        cyc(0, 0, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
